stage4_enfast_nr: RTL and testbench

STAGE4_ENFAST_NR -- requirements
Module: stage4_enfast_nr

---
 rtl/stage4_enfast_nr_if.sv | 25 ++
 rtl/stage4_enfast_nr.sv | 111 +++++++++++
 tb/tb_stage4_enfast_nr.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stage4_enfast_nr_if.sv
// Handshake bundle for the FAST encoder stage: decoded head fields in, encoded message out.
// The slave modport is the encoder's view; the master modport is the producer/consumer side.
interface stage4_enfast_nr_if #(
  parameter int FAST_BITS  = 344,
  parameter int FIELD_BITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FIELD_BITS-1:0] pid_in;
  logic [FIELD_BITS-1:0] mc_in;
  logic [FIELD_BITS-1:0] mt_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [FAST_BITS-1:0]  fast_out;

  modport master (
    output in_valid, pid_in, mc_in, mt_in, out_ready,
    input  in_ready, out_valid, fast_out
  );

  modport slave (
    input  in_valid, pid_in, mc_in, mt_in, out_ready,
    output in_ready, out_valid, fast_out
  );
endinterface

// File: rtl/stage4_enfast_nr.sv
// FAST encoder stage: copy-operator dictionary on PID/MC/MT, presence-map build,
// left-packed payload and a single registered output slot with skid-free backpressure.
module stage4_enfast_nr #(
  parameter int FAST_BITS  = 344,
  parameter int FIELD_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stage4_enfast_nr_if.slave     bus,
  input  logic                  dict_clear,
  output logic [FIELD_BITS-1:0] field_PID1,
  output logic [FIELD_BITS-1:0] field_MC1,
  output logic [FIELD_BITS-1:0] field_MT1,
  output logic [15:0]           msg_cnt
);

  localparam int PAY_BITS = 3 * FIELD_BITS;
  localparam int PAD_BITS = FAST_BITS - 16 - PAY_BITS;

  logic [FIELD_BITS-1:0] pid_r, mc_r, mt_r;
  logic                  pid_vld_r, mc_vld_r, mt_vld_r;
  logic                  out_valid_r;
  logic [FAST_BITS-1:0]  fast_r;
  logic [15:0]           cnt_r;

  logic                  in_ready_s;
  logic                  acc_s;
  logic                  cp_pid_s, cp_mc_s, cp_mt_s;
  logic [PAY_BITS-1:0]   payload_s;
  logic [FAST_BITS-1:0]  fast_nxt_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign acc_s      = bus.in_valid && in_ready_s;

  // A same-cycle clear wins over the stored entries, forcing every field present.
  assign cp_pid_s = pid_vld_r && !dict_clear && (pid_r == bus.pid_in);
  assign cp_mc_s  = mc_vld_r  && !dict_clear && (mc_r  == bus.mc_in);
  assign cp_mt_s  = mt_vld_r  && !dict_clear && (mt_r  == bus.mt_in);

  // Left-pack the present fields in PID, MC, MT order.
  always_comb begin
    payload_s = {PAY_BITS{1'b0}};
    case ({cp_pid_s, cp_mc_s, cp_mt_s})
      3'b000:  payload_s = {bus.pid_in, bus.mc_in, bus.mt_in};
      3'b001:  payload_s = {bus.pid_in, bus.mc_in, {FIELD_BITS{1'b0}}};
      3'b010:  payload_s = {bus.pid_in, bus.mt_in, {FIELD_BITS{1'b0}}};
      3'b011:  payload_s = {bus.pid_in, {(2*FIELD_BITS){1'b0}}};
      3'b100:  payload_s = {bus.mc_in, bus.mt_in, {FIELD_BITS{1'b0}}};
      3'b101:  payload_s = {bus.mc_in, {(2*FIELD_BITS){1'b0}}};
      3'b110:  payload_s = {bus.mt_in, {(2*FIELD_BITS){1'b0}}};
      3'b111:  payload_s = {PAY_BITS{1'b0}};
      default: payload_s = {PAY_BITS{1'b0}};
    endcase
  end

  assign fast_nxt_s = {1'b1, cp_pid_s, cp_mc_s, cp_mt_s, 12'd0, payload_s, {PAD_BITS{1'b0}}};

  // Dictionary: load on acceptance, drop valid flags on a clear with no acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_r     <= {FIELD_BITS{1'b0}};
      mc_r      <= {FIELD_BITS{1'b0}};
      mt_r      <= {FIELD_BITS{1'b0}};
      pid_vld_r <= 1'b0;
      mc_vld_r  <= 1'b0;
      mt_vld_r  <= 1'b0;
    end else if (acc_s) begin
      pid_r     <= bus.pid_in;
      mc_r      <= bus.mc_in;
      mt_r      <= bus.mt_in;
      pid_vld_r <= 1'b1;
      mc_vld_r  <= 1'b1;
      mt_vld_r  <= 1'b1;
    end else if (dict_clear) begin
      pid_vld_r <= 1'b0;
      mc_vld_r  <= 1'b0;
      mt_vld_r  <= 1'b0;
    end
  end

  // Output slot: holds the encoded message until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      fast_r      <= {FAST_BITS{1'b0}};
    end else if (acc_s) begin
      out_valid_r <= 1'b1;
      fast_r      <= fast_nxt_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Accepted-message counter, wraps modulo 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (acc_s) begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.fast_out  = fast_r;
  assign field_PID1    = pid_r;
  assign field_MC1     = mc_r;
  assign field_MT1     = mt_r;
  assign msg_cnt       = cnt_r;

endmodule

// File: tb/tb_stage4_enfast_nr.sv
// Bench for stage4_enfast_nr: directed vectors with literal expectations, a behavioural
// encoder model compared every cycle, and a loopback decoder that must recover every triple.
module tb_stage4_enfast_nr;

  logic        clk;
  logic        rst_n;
  logic        dict_clear;
  logic [7:0]  field_PID1, field_MC1, field_MT1;
  logic [15:0] msg_cnt;

  stage4_enfast_nr_if #(.FAST_BITS(344), .FIELD_BITS(8)) bus ();

  stage4_enfast_nr #(.FAST_BITS(344), .FIELD_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dict_clear (dict_clear),
    .field_PID1 (field_PID1),
    .field_MC1  (field_MC1),
    .field_MT1  (field_MT1),
    .msg_cnt    (msg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]   m_val [3];
  bit           m_vld [3];
  bit           m_ov = 1'b0;
  logic [343:0] m_fast = '0;
  logic [15:0]  m_cnt = 16'd0;
  logic [23:0]  exp_q [$];
  logic [7:0]   dec_val [3];

  task automatic chk(input string nm, input logic [343:0] act, input logic [343:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural encoder: presence map and payload built from a byte list per message.
  initial begin
    logic [7:0]  inb [3];
    logic [7:0]  bytes [$];
    logic [15:0] pm;
    bit          acc, cp, rdy;
    for (int i = 0; i < 3; i++) begin m_val[i] = 8'd0; m_vld[i] = 1'b0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin m_val[i] = 8'd0; m_vld[i] = 1'b0; end
        m_ov = 1'b0; m_fast = '0; m_cnt = 16'd0; exp_q.delete();
      end else begin
        rdy = !m_ov || bus.out_ready;
        acc = bus.in_valid && rdy;
        if (acc) begin
          inb[0] = bus.pid_in; inb[1] = bus.mc_in; inb[2] = bus.mt_in;
          pm = 16'h8000;
          bytes.delete();
          for (int i = 0; i < 3; i++) begin
            cp = m_vld[i] && !dict_clear && (m_val[i] == inb[i]);
            if (cp) pm = pm | (16'h4000 >> i);
            else bytes.push_back(inb[i]);
            m_val[i] = inb[i];
            m_vld[i] = 1'b1;
          end
          m_fast = '0;
          m_fast[343:328] = pm;
          for (int j = 0; j < bytes.size(); j++) m_fast[327-8*j -: 8] = bytes[j];
          exp_q.push_back({inb[0], inb[1], inb[2]});
          m_ov  = 1'b1;
          m_cnt = m_cnt + 16'd1;
        end else begin
          if (bus.out_ready) m_ov = 1'b0;
          if (dict_clear) for (int i = 0; i < 3; i++) m_vld[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus loopback decode of each transferred message.
  initial begin
    logic [15:0] pm;
    logic [7:0]  got [3];
    logic [23:0] e;
    int          k;
    for (int i = 0; i < 3; i++) dec_val[i] = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", 344'(bus.in_ready), 344'(!m_ov || bus.out_ready));
        chk("out_valid", 344'(bus.out_valid), 344'(m_ov));
        chk("msg_cnt", 344'(msg_cnt), 344'(m_cnt));
        chk("field_PID1", 344'(field_PID1), 344'(m_val[0]));
        chk("field_MC1", 344'(field_MC1), 344'(m_val[1]));
        chk("field_MT1", 344'(field_MT1), 344'(m_val[2]));
        if (m_ov) chk("fast_out", bus.fast_out, m_fast);
        if (bus.out_valid && bus.out_ready) begin
          pm = bus.fast_out[343:328];
          k = 0;
          for (int i = 0; i < 3; i++) begin
            if (pm[14-i]) got[i] = dec_val[i];
            else begin got[i] = bus.fast_out[327-8*k -: 8]; k++; end
            dec_val[i] = got[i];
          end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL loopback_extra actual=%0h expected=none", {got[0], got[1], got[2]});
          end else begin
            e = exp_q.pop_front();
            chk("loopback", 344'({got[0], got[1], got[2]}), 344'(e));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic [7:0] m, input logic [7:0] t, input logic clr);
    bit r, done;
    done = 1'b0;
    bus.in_valid = 1'b1; bus.pid_in = p; bus.mc_in = m; bus.mt_in = t; dict_clear = clr;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk); r = bus.in_ready;
      @(posedge clk); #1; done = r;
    end
    bus.in_valid = 1'b0; dict_clear = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic set_in(input logic [7:0] p, input logic [7:0] m, input logic [7:0] t);
    bus.pid_in = p; bus.mc_in = m; bus.mt_in = t;
  endtask

  initial begin
    logic [343:0] e;
    int n;
    rst_n = 1'b0; dict_clear = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_in(8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 344'(bus.out_valid), 344'(0));
    chk("rst_fast_out", bus.fast_out, 344'(0));
    chk("rst_msg_cnt", 344'(msg_cnt), 344'(0));
    chk("rst_in_ready", 344'(bus.in_ready), 344'(1));
    chk("rst_fields", 344'({field_PID1, field_MC1, field_MT1}), 344'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'h11, 8'h22, 8'h33, 1'b0);
    e = '0; e[343:304] = 40'h8000_112233;
    chk("first_full", bus.fast_out, e);
    chk("first_valid", 344'(bus.out_valid), 344'(1));
    chk("first_cnt", 344'(msg_cnt), 344'(1));

    send(8'h11, 8'h22, 8'h33, 1'b0);
    chk("repeat_pmap", 344'(bus.fast_out[343:328]), 344'(16'hF000));
    chk("repeat_payload", 344'(bus.fast_out[327:304]), 344'(0));

    send(8'h11, 8'h99, 8'h33, 1'b0);
    chk("mc_pmap", 344'(bus.fast_out[343:328]), 344'(16'hD000));
    chk("mc_byte", 344'(bus.fast_out[327:320]), 344'(8'h99));
    chk("mc_field", 344'(field_MC1), 344'(8'h99));

    send(8'h11, 8'h22, 8'h33, 1'b0);
    send(8'h44, 8'h22, 8'h55, 1'b0);
    e = '0; e[343:312] = 32'hA000_4455;
    chk("pm_a000", bus.fast_out, e);

    // stall with a pending message and a clear arriving mid-stall
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; set_in(8'h77, 8'h88, 8'h99);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 344'(bus.in_ready), 344'(0));
      chk("stall_hold", bus.fast_out, e);
      chk("stall_cnt", 344'(msg_cnt), 344'(5));
      @(posedge clk); #1;
      dict_clear = (c == 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_pmap", 344'(bus.fast_out[343:304]), 344'(40'h8000_778899));
    chk("release_cnt", 344'(msg_cnt), 344'(6));

    set_in(8'h21, 8'h22, 8'h23); @(posedge clk); #1;
    set_in(8'h21, 8'h22, 8'h24); @(posedge clk); #1;
    chk("b2b_e000", 344'(bus.fast_out[343:320]), 344'(24'hE000_24));
    set_in(8'h21, 8'h22, 8'h24); @(posedge clk); #1;
    chk("b2b_f000", 344'(bus.fast_out[343:328]), 344'(16'hF000));
    set_in(8'h30, 8'h22, 8'h24); @(posedge clk); #1;
    chk("b2b_b000", 344'(bus.fast_out[343:320]), 344'(24'hB000_30));
    bus.in_valid = 1'b0;
    chk("b2b_cnt", 344'(msg_cnt), 344'(10));

    for (int c = 0; c < 80; c++) begin
      bus.in_valid  = ($urandom % 2) == 0;
      bus.out_ready = ($urandom % 4) != 0;
      dict_clear    = ($urandom % 8) == 0;
      set_in(($urandom % 2) ? 8'h10 : 8'h20, ($urandom % 2) ? 8'h10 : 8'h20, 8'h10);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; dict_clear = 1'b0;
    repeat (3) @(posedge clk); #1;

    send(8'h11, 8'h22, 8'h33, 1'b0);
    send(8'h11, 8'h22, 8'h33, 1'b1);
    chk("clr_acc_pmap", 344'(bus.fast_out[343:304]), 344'(40'h8000_112233));
    send(8'h11, 8'h22, 8'h33, 1'b0);
    chk("after_clr_pmap", 344'(bus.fast_out[343:328]), 344'(16'hF000));

    n = 65535 - int'(m_cnt);
    bus.in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_in(8'(i), 8'(i >> 8), 8'h5A);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("cnt_ffff", 344'(msg_cnt), 344'(16'hFFFF));
    send(8'h01, 8'h02, 8'h03, 1'b0);
    chk("cnt_wrap", 344'(msg_cnt), 344'(0));

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(8'h66, 8'h77, 8'h88, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_valid", 344'(bus.out_valid), 344'(0));
    chk("midrst_fast", bus.fast_out, 344'(0));
    chk("midrst_cnt", 344'(msg_cnt), 344'(0));
    chk("midrst_fields", 344'({field_PID1, field_MC1, field_MT1}), 344'(0));
    chk("midrst_in_ready", 344'(bus.in_ready), 344'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    send(8'h11, 8'h22, 8'h33, 1'b0);
    chk("postrst_pmap", 344'(bus.fast_out[343:304]), 344'(40'h8000_112233));
    chk("postrst_cnt", 344'(msg_cnt), 344'(1));
    repeat (2) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
